// File: rtl/ctrl_pkg.sv
// Shared control-word definitions for the pipeline control unit.
// Opcodes, per-stage control field layouts and the bubble constant.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_fields_t;

  typedef struct packed {
    logic       mem_write;
    logic       mem_read;
    wb_fields_t wb;
  } mem_fields_t;

  typedef struct packed {
    logic        reg_dst;
    logic [1:0]  alu_op;
    logic        alu_src;
    mem_fields_t mem;
  } ex_fields_t;

  // Full 10-bit decoded word; branch/jump are consumed in ID and never staged.
  typedef struct packed {
    ex_fields_t ex;
    logic       branch;
    logic       jump;
  } ctrl_word_t;

  localparam int CW_W      = $bits(ctrl_word_t);
  localparam int CW_JUMP   = 0;
  localparam int CW_BRANCH = 1;

  localparam ctrl_word_t NOP_WORD = '0;

endpackage

// File: rtl/ctrl_hazard_det.sv
// Combinational stall detection: load-use and beq operand hazards.
// Register $0 never matches, so it can never cause a stall.
module ctrl_hazard_det #(
  parameter int REG_AW = 5
) (
  input  logic              use_rs_i,
  input  logic              use_rt_i,
  input  logic              is_beq_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              mem_mem_read_i,
  input  logic [REG_AW-1:0] mem_dst_i,
  output logic              stall_o
);

  logic ex_hit_rs, ex_hit_rt, mem_hit;
  logic load_use, br_ex, br_mem;

  assign ex_hit_rs = (ex_dst_i != '0) && (ex_dst_i == rs_i);
  assign ex_hit_rt = (ex_dst_i != '0) && (ex_dst_i == rt_i);
  assign mem_hit   = (mem_dst_i != '0) && ((mem_dst_i == rs_i) || (mem_dst_i == rt_i));

  assign load_use = ex_mem_read_i && ((use_rs_i && ex_hit_rs) || (use_rt_i && ex_hit_rt));
  // beq compares in ID, so any producer still in EX, or a load in MEM, is too late to forward.
  assign br_ex    = is_beq_i && ex_reg_write_i && (ex_hit_rs || ex_hit_rt);
  assign br_mem   = is_beq_i && mem_mem_read_i && mem_hit;

  assign stall_o = load_use || br_ex || br_mem;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Main pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control staging, hazard stalls.
// Optional perf counters are built when CTRL_PERF_CNT_EN is defined.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [REG_AW-1:0]  rs_i,
  input  logic [REG_AW-1:0]  rt_i,
  input  logic [REG_AW-1:0]  rd_i,
  input  logic               br_eq_i,
  output logic               pc_write_o,
  output logic               if_id_write_o,
  output logic               if_id_flush_o,
  output logic               id_jump_o,
  output logic               id_branch_o,
  output logic [ALUOP_W+1:0] ex_ctrl_o,
  output logic [REG_AW-1:0]  ex_dst_o,
  output logic [1:0]         mem_ctrl_o,
  output logic [1:0]         wb_ctrl_o,
  output logic [REG_AW-1:0]  wb_dst_o,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o,
`endif
  output logic               illegal_o
);

  ctrl_word_t        dec_word;
  logic [CW_W-1:0]   dec_bits;
  logic              use_rs, use_rt, illegal;
  logic              stall;
  logic [REG_AW-1:0] id_dst;

  ex_fields_t        id_ex_d, id_ex_q;
  logic [REG_AW-1:0] id_ex_dst_d, id_ex_dst_q;
  mem_fields_t       ex_mem_q;
  logic [REG_AW-1:0] ex_mem_dst_q;
  wb_fields_t        mem_wb_q;
  logic [REG_AW-1:0] mem_wb_dst_q;

  always_comb begin
    dec_word = NOP_WORD;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    illegal  = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        dec_word.ex.reg_dst          = 1'b1;
        dec_word.ex.mem.wb.reg_write = 1'b1;
        dec_word.ex.alu_op           = 2'b10;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_ADDI: begin
        dec_word.ex.alu_src          = 1'b1;
        dec_word.ex.mem.wb.reg_write = 1'b1;
        use_rs = 1'b1;
      end
      OP_LW: begin
        dec_word.ex.alu_src           = 1'b1;
        dec_word.ex.mem.mem_read      = 1'b1;
        dec_word.ex.mem.wb.reg_write  = 1'b1;
        dec_word.ex.mem.wb.mem_to_reg = 1'b1;
        use_rs = 1'b1;
      end
      OP_SW: begin
        dec_word.ex.alu_src       = 1'b1;
        dec_word.ex.mem.mem_write = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQ: begin
        dec_word.branch    = 1'b1;
        dec_word.ex.alu_op = 2'b01;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J:    dec_word.jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  assign dec_bits = dec_word;
  assign id_dst   = dec_word.ex.reg_dst ? rd_i : rt_i;

  ctrl_hazard_det #(.REG_AW(REG_AW)) u_hazard (
    .use_rs_i       (use_rs),
    .use_rt_i       (use_rt),
    .is_beq_i       (dec_bits[CW_BRANCH]),
    .rs_i           (rs_i),
    .rt_i           (rt_i),
    .ex_mem_read_i  (id_ex_q.mem.mem_read),
    .ex_reg_write_i (id_ex_q.mem.wb.reg_write),
    .ex_dst_i       (id_ex_dst_q),
    .mem_mem_read_i (ex_mem_q.mem_read),
    .mem_dst_i      (ex_mem_dst_q),
    .stall_o        (stall)
  );

  assign id_ex_d     = stall ? NOP_WORD.ex : dec_word.ex;
  assign id_ex_dst_d = stall ? '0 : id_dst;

  // ID/EX -> EX/MEM -> MEM/WB; later stages never back-pressure
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_ex_q      <= '0;
      id_ex_dst_q  <= '0;
      ex_mem_q     <= '0;
      ex_mem_dst_q <= '0;
      mem_wb_q     <= '0;
      mem_wb_dst_q <= '0;
    end else begin
      id_ex_q      <= id_ex_d;
      id_ex_dst_q  <= id_ex_dst_d;
      ex_mem_q     <= id_ex_q.mem;
      ex_mem_dst_q <= id_ex_dst_q;
      mem_wb_q     <= ex_mem_q.wb;
      mem_wb_dst_q <= ex_mem_dst_q;
    end
  end

  assign pc_write_o    = !stall;
  assign if_id_write_o = !stall;
  assign id_branch_o   = dec_bits[CW_BRANCH] && br_eq_i && !stall;
  assign id_jump_o     = dec_bits[CW_JUMP] && !stall;
  assign if_id_flush_o = id_branch_o || id_jump_o;
  assign illegal_o     = illegal;

  assign ex_ctrl_o  = {id_ex_q.reg_dst, id_ex_q.alu_op, id_ex_q.alu_src};
  assign ex_dst_o   = id_ex_dst_q;
  assign mem_ctrl_o = {ex_mem_q.mem_write, ex_mem_q.mem_read};
  assign wb_ctrl_o  = {mem_wb_q.mem_to_reg, mem_wb_q.reg_write};
  assign wb_dst_o   = mem_wb_dst_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign stall_cnt_d = stall         ? sat_inc(stall_cnt_q) : stall_cnt_q;
  assign flush_cnt_d = if_id_flush_o ? sat_inc(flush_cnt_q) : flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  // Counters compiled out; stalls and flushes are visible only through the enables.
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an instruction-level model.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       br_eq;

  logic       pc_write_o, if_id_write_o, if_id_flush_o, id_jump_o, id_branch_o;
  logic [3:0] ex_ctrl_o;
  logic [4:0] ex_dst_o, wb_dst_o;
  logic [1:0] mem_ctrl_o, wb_ctrl_o;
  logic       illegal_o;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  ctrl_pipe_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .op_i          (op),
    .rs_i          (rs),
    .rt_i          (rt),
    .rd_i          (rd),
    .br_eq_i       (br_eq),
    .pc_write_o    (pc_write_o),
    .if_id_write_o (if_id_write_o),
    .if_id_flush_o (if_id_flush_o),
    .id_jump_o     (id_jump_o),
    .id_branch_o   (id_branch_o),
    .ex_ctrl_o     (ex_ctrl_o),
    .ex_dst_o      (ex_dst_o),
    .mem_ctrl_o    (mem_ctrl_o),
    .wb_ctrl_o     (wb_ctrl_o),
    .wb_dst_o      (wb_dst_o),
`ifdef CTRL_PERF_CNT_EN
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
`endif
    .illegal_o     (illegal_o)
  );

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // One in-flight instruction as seen by the later stages.
  typedef struct packed {
    bit       writes_reg;
    bit       loads;
    bit       stores;
    bit       load_to_reg;
    bit       uses_rd;
    bit       imm_operand;
    bit [1:0] alu_mode;
    bit [4:0] dst;
  } instr_t;

  // Instruction semantics from the ISA description, not from any encoding in the DUT.
  function automatic void describe(input logic [5:0] o, output instr_t ins,
                                   output bit reads_rs, output bit reads_rt,
                                   output bit is_beq, output bit is_j, output bit bad);
    ins = '0; reads_rs = 0; reads_rt = 0; is_beq = 0; is_j = 0; bad = 0;
    if (o == R) begin
      ins.writes_reg = 1; ins.uses_rd = 1; ins.alu_mode = 2'd2; reads_rs = 1; reads_rt = 1;
    end else if (o == ADDI) begin
      ins.writes_reg = 1; ins.imm_operand = 1; reads_rs = 1;
    end else if (o == LW) begin
      ins.writes_reg = 1; ins.loads = 1; ins.load_to_reg = 1; ins.imm_operand = 1; reads_rs = 1;
    end else if (o == SW) begin
      ins.stores = 1; ins.imm_operand = 1; reads_rs = 1; reads_rt = 1;
    end else if (o == BEQ) begin
      is_beq = 1; ins.alu_mode = 2'd1; reads_rs = 1; reads_rt = 1;
    end else if (o == J) begin
      is_j = 1;
    end else begin
      bad = 1;
    end
  endfunction

  instr_t in_ex = '0, in_mem = '0, in_wb = '0;
  int     m_stalls = 0, m_flushes = 0;

  initial begin : compare
    instr_t cur;
    bit r_rs, r_rt, beq, jmp, bad, stall, taken_b, taken_j;
    @(posedge clk);
    forever begin
      @(negedge clk);
      describe(op, cur, r_rs, r_rt, beq, jmp, bad);
      cur.dst = cur.uses_rd ? rd : rt;
      stall = 0;
      if (in_ex.loads && in_ex.dst != 0 &&
          ((r_rs && in_ex.dst == rs) || (r_rt && in_ex.dst == rt))) stall = 1;
      if (beq && in_ex.writes_reg && in_ex.dst != 0 && (in_ex.dst == rs || in_ex.dst == rt)) stall = 1;
      if (beq && in_mem.loads && in_mem.dst != 0 && (in_mem.dst == rs || in_mem.dst == rt)) stall = 1;
      taken_b = beq && br_eq && !stall;
      taken_j = jmp && !stall;

      chk("pc_write", pc_write_o, !stall);
      chk("if_id_write", if_id_write_o, !stall);
      chk("id_branch", id_branch_o, taken_b);
      chk("id_jump", id_jump_o, taken_j);
      chk("if_id_flush", if_id_flush_o, taken_b || taken_j);
      chk("illegal", illegal_o, bad);
      chk("ex_ctrl", ex_ctrl_o, {in_ex.uses_rd, in_ex.alu_mode, in_ex.imm_operand});
      chk("ex_dst", ex_dst_o, in_ex.dst);
      chk("mem_ctrl", mem_ctrl_o, {in_mem.stores, in_mem.loads});
      chk("wb_ctrl", wb_ctrl_o, {in_wb.load_to_reg, in_wb.writes_reg});
      chk("wb_dst", wb_dst_o, in_wb.dst);
`ifdef CTRL_PERF_CNT_EN
      chk("stall_cnt", stall_cnt_o, m_stalls);
      chk("flush_cnt", flush_cnt_o, m_flushes);
`endif
      if (rst) begin
        in_ex = '0; in_mem = '0; in_wb = '0; m_stalls = 0; m_flushes = 0;
      end else begin
        in_wb  = in_mem;
        in_mem = in_ex;
        in_ex  = stall ? instr_t'('0) : cur;
        if (stall && m_stalls < 65535) m_stalls++;
        if ((taken_b || taken_j) && m_flushes < 65535) m_flushes++;
      end
    end
  end

  task automatic step(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic eq);
    @(posedge clk); #1;
    op = o; rs = s; rt = t; rd = d; br_eq = eq;
  endtask

  task automatic settle;
    @(negedge clk); #1;
  endtask

  initial begin : drive
    rst = 1'b1; op = R; rs = 0; rt = 0; rd = 0; br_eq = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle;
    chk("reset_ex_ctrl", ex_ctrl_o, 0);
    chk("reset_wb_ctrl", wb_ctrl_o, 0);

    // lw $2 ; add $3,$2,$4
    step(LW, 1, 2, 0, 0); settle; chk("t1_lw_go", pc_write_o, 1);
    step(R, 2, 4, 3, 0);  settle; chk("t1_stall_pc", pc_write_o, 0); chk("t1_stall_ifid", if_id_write_o, 0);
    step(R, 2, 4, 3, 0);  settle; chk("t1_bubble_ex", ex_ctrl_o, 0); chk("t1_resume", pc_write_o, 1);
    chk("t1_lw_mem", mem_ctrl_o, 2'b01);
    step(R, 0, 0, 0, 0);  settle; chk("t1_add_ex", ex_ctrl_o, 4'b1100); chk("t1_add_dst", ex_dst_o, 3);

    // addi $5 ; beq $5,$6 taken
    step(ADDI, 0, 5, 0, 0); settle;
    step(BEQ, 5, 6, 0, 1);  settle; chk("t2_stall", pc_write_o, 0); chk("t2_br_masked", id_branch_o, 0);
    chk("t2_flush_masked", if_id_flush_o, 0);
    step(BEQ, 5, 6, 0, 1);  settle; chk("t2_branch", id_branch_o, 1); chk("t2_flush", if_id_flush_o, 1);

    // lw $7 ; nop ; beq $7,$0
    step(LW, 0, 7, 0, 0);
    step(R, 0, 0, 0, 0);
    step(BEQ, 7, 0, 0, 1);  settle; chk("t3_stall", pc_write_o, 0); chk("t3_br_masked", id_branch_o, 0);
    step(BEQ, 7, 0, 0, 1);  settle; chk("t3_branch", id_branch_o, 1); chk("t3_resume", pc_write_o, 1);

    // j
    step(J, 0, 0, 0, 0);    settle; chk("t4_jump", id_jump_o, 1); chk("t4_flush", if_id_flush_o, 1);
    step(R, 0, 0, 0, 0);    settle; chk("t4_j_ex", ex_ctrl_o, 0); chk("t4_jump_gone", id_jump_o, 0);

    // lw $0 ; add $1,$0,$0 ; illegal
    step(LW, 0, 0, 0, 0);
    step(R, 0, 0, 1, 0);    settle; chk("t5_r0_nostall", pc_write_o, 1);
    step(6'h3F, 0, 0, 0, 0); settle; chk("t5_illegal", illegal_o, 1);
    step(J, 0, 0, 0, 0);
    step(J, 0, 0, 0, 0);    settle; chk("t5_add_wb", wb_ctrl_o, 2'b01); chk("t5_add_wb_dst", wb_dst_o, 1);
    step(J, 0, 0, 0, 0);    settle; chk("t5_nop_wb", wb_ctrl_o, 0);

    // reset while lw sits in EX
    step(LW, 0, 3, 0, 0);
    step(R, 3, 0, 4, 0); rst = 1'b1;
    settle; chk("t6_pre_rst_stall", pc_write_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    settle;
    chk("t6_mem_clr", mem_ctrl_o, 0); chk("t6_wb_clr", wb_ctrl_o, 0); chk("t6_no_stall", pc_write_o, 1);
`ifdef CTRL_PERF_CNT_EN
    chk("t6_stall_cnt_clr", stall_cnt_o, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [5:0] o;
      case ($urandom_range(0, 7))
        0: o = R;
        1: o = ADDI;
        2, 6: o = LW;
        3: o = SW;
        4: o = BEQ;
        5: o = J;
        default: o = 6'($urandom);
      endcase
      step(o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom));
      rst = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    settle;
    settle;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
